// File: rtl/fabric_cfg_loader_pkg.sv
// Shared types and constants for the fabric configuration loader.
// The default CFG_BITS is the sum of the per-region select counts of the 4x4 fabric.
package fabric_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      PAYLOAD,
      CSUM,
      RESP
   } state_t;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_LEN   = 2'b01;
   localparam logic [1:0] ERR_CSUM  = 2'b10;
   localparam logic [1:0] ERR_ABORT = 2'b11;

   localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

   localparam int ROUTING_BITS     = 750;
   localparam int SWITCH_BITS      = 1728;
   localparam int LOGIC_BITS       = 80;
   localparam int IO_BITS          = 80;
   localparam int DEFAULT_CFG_BITS = ROUTING_BITS + SWITCH_BITS + LOGIC_BITS + IO_BITS;

   function automatic int words_for(input int bits, input int word_w);
      return (bits + word_w - 1) / word_w;
   endfunction

endpackage

// File: rtl/fabric_cfg_loader_if.sv
// Valid/ready word stream feeding the configuration loader.
interface fabric_cfg_loader_if #(
   parameter int WORD_W = 8
);

   logic [WORD_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;

   modport master (output s_data, output s_valid, input s_ready);
   modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/fabric_cfg_loader_shadow_reg.sv
// Shadow register assembled one word at a time; the last word is truncated
// so that only CFG_BITS flops exist.
module cfg_shadow_reg
   import fabric_cfg_pkg::*;
#(
   parameter int  CFG_BITS = DEFAULT_CFG_BITS,
   parameter int  WORD_W   = 8,
   localparam int N_WORDS  = words_for(CFG_BITS, WORD_W),
   localparam int IDX_W    = $clog2(N_WORDS + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                we,
   input  logic [IDX_W-1:0]    idx,
   input  logic [WORD_W-1:0]   wdata,
   output logic [CFG_BITS-1:0] shadow
);

   for (genvar k = 0; k < N_WORDS; k++) begin : g_word
      localparam int LO  = k * WORD_W;
      localparam int WID = (CFG_BITS - LO < WORD_W) ? (CFG_BITS - LO) : WORD_W;

      logic [WID-1:0] word_q;

      // Each word owns its own slice, so a write never touches neighbouring words.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            word_q <= '0;
         end else if (we && (idx == IDX_W'(k))) begin
            word_q <= wdata[WID-1:0];
         end
      end

      assign shadow[LO +: WID] = word_q;
   end

endmodule

// File: rtl/fabric_cfg_loader.sv
// Framed serial configuration loader: sync, 16-bit length, payload, checksum,
// then an atomic commit of the shadow register onto the live configuration bus.
module fabric_cfg_loader
   import fabric_cfg_pkg::*;
#(
   parameter int         CFG_BITS  = DEFAULT_CFG_BITS,
   parameter int         WORD_W    = 8,
   parameter logic [7:0] SYNC_WORD = DEFAULT_SYNC_WORD
) (
   input  logic                 clk,
   input  logic                 rst_n,
   fabric_cfg_loader_if.slave   s_if,
   input  logic                 abort,
   output logic [CFG_BITS-1:0]  cfg_out,
   output logic                 cfg_valid,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic [1:0]           err_code
);

   localparam int N_WORDS = words_for(CFG_BITS, WORD_W);
   localparam int IDX_W   = $clog2(N_WORDS + 1);

   state_t              state;
   state_t              next_state;
   logic [7:0]          len_hi;
   logic [IDX_W-1:0]    idx;
   logic [WORD_W-1:0]   acc;
   logic [CFG_BITS-1:0] shadow;
   logic                xfer;
   logic                is_sync;
   logic                last_word;
   logic                len_ok;
   logic                csum_ok;
   logic                abortable;

   assign s_if.s_ready = (state != RESP) && !abort;
   assign xfer         = s_if.s_valid && s_if.s_ready;
   assign is_sync      = s_if.s_data[7:0] == SYNC_WORD;
   assign last_word    = idx == IDX_W'(N_WORDS - 1);
   assign len_ok       = {len_hi, s_if.s_data[7:0]} == 16'(N_WORDS);
   assign csum_ok      = s_if.s_data == acc;
   assign abortable    = state inside {LEN_HI, LEN_LO, PAYLOAD, CSUM};
   assign busy         = state != IDLE;

   cfg_shadow_reg #(
      .CFG_BITS (CFG_BITS),
      .WORD_W   (WORD_W)
   ) u_shadow (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (xfer && (state == PAYLOAD)),
      .idx    (idx),
      .wdata  (s_if.s_data),
      .shadow (shadow)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Abort takes priority over any word offered in the same cycle.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (xfer && is_sync) next_state = LEN_HI;
         LEN_HI:  if (abort) next_state = RESP;
                  else if (xfer) next_state = LEN_LO;
         LEN_LO:  if (abort) next_state = RESP;
                  else if (xfer) next_state = len_ok ? PAYLOAD : RESP;
         PAYLOAD: if (abort) next_state = RESP;
                  else if (xfer && last_word) next_state = CSUM;
         CSUM:    if (abort || xfer) next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // The live configuration only ever changes on a checksum match.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_hi    <= '0;
         idx       <= '0;
         acc       <= '0;
         cfg_out   <= '0;
         cfg_valid <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_code  <= ERR_NONE;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (xfer && is_sync) begin
                  idx <= '0;
                  acc <= '0;
               end
            end
            LEN_HI: begin
               if (xfer) len_hi <= s_if.s_data[7:0];
            end
            LEN_LO: begin
               if (xfer && !len_ok) begin
                  err      <= 1'b1;
                  err_code <= ERR_LEN;
               end
            end
            PAYLOAD: begin
               if (xfer) begin
                  acc <= acc + s_if.s_data;
                  idx <= idx + IDX_W'(1);
               end
            end
            CSUM: begin
               if (xfer) begin
                  if (csum_ok) begin
                     cfg_out   <= shadow;
                     cfg_valid <= 1'b1;
                     done      <= 1'b1;
                     err_code  <= ERR_NONE;
                  end else begin
                     err      <= 1'b1;
                     err_code <= ERR_CSUM;
                  end
               end
            end
            default: begin
            end
         endcase
         if (abort && abortable) begin
            err      <= 1'b1;
            err_code <= ERR_ABORT;
         end
      end
   end

endmodule
